// File: rtl/div_share_pkg.sv
// Shared configuration and tag layout for the divider-sharing controller.
package div_share_pkg;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int N    = 16;
  localparam int M    = 8;
  localparam int LAT  = 9;

  // Quotient width of the restoring divider; one divider cell per quotient bit.
  localparam int Q = N - M + 1;

  // The tag pipeline is only aligned with the divider when these agree.
  localparam bit LAT_OK = (LAT == Q);

  localparam int TAGW = 1 + IDW + 1;
  localparam int IFW  = $clog2(LAT + 1);
  // Counts down the cycles after reset in which stale divider results may still emerge.
  localparam int FLW  = $clog2(LAT + 2);

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
    logic           err;
  } tag_t;

endpackage

// File: rtl/div_share_if.sv
// Requester, divider and response signals of the divider-sharing controller.
interface div_share_if;
  import div_share_pkg::*;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_dividend;
  logic [NREQ*M-1:0] req_divisor;
  logic [NREQ-1:0]   req_ready;

  logic              div_en;
  logic [N-1:0]      div_dividend;
  logic [M-1:0]      div_divisor;
  logic              div_rdy;
  logic [Q-1:0]      div_quot;
  logic [M-1:0]      div_rem;

  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [Q-1:0]      rsp_quot;
  logic [M-1:0]      rsp_rem;
  logic              rsp_err;

  logic [IFW-1:0]    inflight;
  logic              sync_err;

  // Environment side: requesters plus the divider datapath.
  modport master (
    output req_valid, req_dividend, req_divisor, div_rdy, div_quot, div_rem,
    input  req_ready, div_en, div_dividend, div_divisor,
           rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_err, inflight, sync_err
  );

  // Controller side.
  modport slave (
    input  req_valid, req_dividend, req_divisor, div_rdy, div_quot, div_rem,
    output req_ready, div_en, div_dividend, div_divisor,
           rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_err, inflight, sync_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from ptr+1 upward (wrapping) for the first request.
module rr_arbiter
  import div_share_pkg::*;
#(
  parameter int RR_NREQ = NREQ,
  parameter int RR_IDW  = IDW
) (
  input  logic [RR_NREQ-1:0] req,
  input  logic [RR_IDW-1:0]  ptr,
  output logic [RR_NREQ-1:0] grant,
  output logic [RR_IDW-1:0]  idx,
  output logic               any
);

  // First requester after the pointer wins; nothing granted when no request.
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 1; k <= RR_NREQ; k++) begin
      j = (int'(ptr) + k) % RR_NREQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = RR_IDW'(j);
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one pipelined restoring divider among NREQ requesters; requester id and
// error flags travel in a tag pipeline aligned with the divider latency.
module div_share_ctrl
  import div_share_pkg::*;
(
  input logic  clk,
  input logic  rst,
  div_share_if.slave bus
);

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  ptr;
  logic            gnt_any;
  logic            take;
  logic [N-1:0]    sel_dividend;
  logic [M-1:0]    sel_divisor;
  logic            sel_err;
  logic [IDW-1:0]  iss_id;
  logic            iss_err;
  tag_t            pipe [LAT];
  tag_t            exit_tag;
  logic [FLW-1:0]  flush_cnt;

  if (!LAT_OK || ($bits(tag_t) != TAGW)) begin : g_cfg_check
    $error("div_share_ctrl: LAT must equal N-M+1");
  end

  rr_arbiter #(.RR_NREQ(NREQ), .RR_IDW(IDW)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // No grant is offered while reset is asserted so no transfer is lost.
  assign take          = gnt_any & ~rst;
  assign bus.req_ready = rst ? '0 : grant;
  assign sel_dividend  = bus.req_dividend[int'(gnt_idx)*N +: N];
  assign sel_divisor   = bus.req_divisor[int'(gnt_idx)*M +: M];
  // Quotient would not fit in Q bits when the top dividend bits reach the divisor.
  assign sel_err       = (sel_divisor == '0) || ((sel_dividend >> Q) >= N'(sel_divisor));
  assign exit_tag      = pipe[LAT-1];

  // Issue register: one division per granted cycle, pointer follows the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.div_en       <= 1'b0;
      bus.div_dividend <= '0;
      bus.div_divisor  <= '0;
      iss_id           <= '0;
      iss_err          <= 1'b0;
      ptr              <= IDW'(NREQ - 1);
    end else begin
      bus.div_en <= take;
      if (take) begin
        bus.div_dividend <= sel_dividend;
        bus.div_divisor  <= sel_divisor;
        iss_id           <= gnt_idx;
        iss_err          <= sel_err;
        ptr              <= gnt_idx;
      end
    end
  end

  // Tag shift register; its last stage lines up with the divider's final stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= '{valid: bus.div_en, id: iss_id, err: iss_err};
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  // Response register: data only updates on a valid exit, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_quot  <= '0;
      bus.rsp_rem   <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= exit_tag.valid;
      if (exit_tag.valid) begin
        bus.rsp_id   <= exit_tag.id;
        bus.rsp_err  <= exit_tag.err;
        bus.rsp_quot <= exit_tag.err ? '1 : bus.div_quot;
        bus.rsp_rem  <= exit_tag.err ? '0 : bus.div_rem;
      end
    end
  end

  // Occupancy counter: issue adds one, tag exit removes one.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.inflight <= '0;
    end else begin
      case ({bus.div_en, exit_tag.valid})
        2'b10:   bus.inflight <= bus.inflight + IFW'(1);
        2'b01:   bus.inflight <= bus.inflight - IFW'(1);
        default: bus.inflight <= bus.inflight;
      endcase
    end
  end

  // Sticky tag/divider disagreement check, muted while dropped operations drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sync_err <= 1'b0;
      flush_cnt    <= FLW'(LAT + 1);
    end else if (flush_cnt != '0) begin
      flush_cnt <= flush_cnt - FLW'(1);
    end else if (exit_tag.valid != bus.div_rdy) begin
      bus.sync_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl with a behavioural LAT-stage divider model.
module tb_div_share_ctrl;
  import div_share_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic force_rdy;
  int   errors = 0;
  int   checks = 0;

  div_share_if bus ();

  div_share_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Divider model: LAT stages, no reset, stage cleared when div_en is low.
  logic [LAT-1:0] mv = '0;
  logic [N-1:0]   md [LAT];
  logic [M-1:0]   ms [LAT];

  always_ff @(posedge clk) begin
    mv    <= {mv[LAT-2:0], bus.div_en};
    md[0] <= bus.div_dividend;
    ms[0] <= bus.div_divisor;
    for (int k = 1; k < LAT; k++) begin
      md[k] <= md[k-1];
      ms[k] <= ms[k-1];
    end
  end

  assign bus.div_rdy = mv[LAT-1] | force_rdy;

  always_comb begin
    bus.div_quot = '0;
    bus.div_rem  = '0;
    if (ms[LAT-1] != '0) begin
      bus.div_quot = Q'(md[LAT-1] / N'(ms[LAT-1]));
      bus.div_rem  = M'(md[LAT-1] % N'(ms[LAT-1]));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input int i, input int dd, input int dv);
    bus.req_valid[i]              = 1'b1;
    bus.req_dividend[i*N +: N]    = N'(dd);
    bus.req_divisor[i*M +: M]     = M'(dv);
  endtask

  initial begin
    rst              = 1'b1;
    force_rdy        = 1'b0;
    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    cyc(3);

    // Reset state
    chk("rst_div_en", 32'(bus.div_en), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_inflight", 32'(bus.inflight), 0);
    chk("rst_sync_err", 32'(bus.sync_err), 0);
    chk("rst_rsp_quot", 32'(bus.rsp_quot), 0);
    bus.req_valid = '1;
    #1 chk("rst_ready_gated", 32'(bus.req_ready), 0);
    bus.req_valid = '0;
    rst = 1'b0;
    cyc(2);

    // Single request: requester 2, 1000/7
    set_req(2, 1000, 7);
    #1 chk("t1_ready", 32'(bus.req_ready), 32'b0100);
    cyc(1);
    bus.req_valid = '0;
    chk("t1_div_en", 32'(bus.div_en), 1);
    chk("t1_div_dividend", 32'(bus.div_dividend), 1000);
    chk("t1_div_divisor", 32'(bus.div_divisor), 7);
    cyc(1);
    chk("t1_div_en_drop", 32'(bus.div_en), 0);
    chk("t1_inflight", 32'(bus.inflight), 1);
    cyc(8);
    chk("t1_rsp_early", 32'(bus.rsp_valid), 0);
    cyc(1);
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("t1_rsp_id", 32'(bus.rsp_id), 2);
    chk("t1_rsp_quot", 32'(bus.rsp_quot), 142);
    chk("t1_rsp_rem", 32'(bus.rsp_rem), 6);
    chk("t1_rsp_err", 32'(bus.rsp_err), 0);
    chk("t1_inflight_done", 32'(bus.inflight), 0);
    cyc(1);
    chk("t1_rsp_pulse", 32'(bus.rsp_valid), 0);
    chk("t1_rsp_hold", 32'(bus.rsp_quot), 142);
    cyc(2);

    // Error cases, back to back
    set_req(3, 500, 0);
    #1 chk("t3_ready_a", 32'(bus.req_ready), 32'b1000);
    cyc(1);
    bus.req_valid = '0;
    set_req(0, 65535, 1);
    #1 chk("t3_ready_b", 32'(bus.req_ready), 32'b0001);
    cyc(1);
    bus.req_valid = '0;
    set_req(1, 511, 1);
    #1 chk("t3_ready_c", 32'(bus.req_ready), 32'b0010);
    cyc(1);
    bus.req_valid = '0;
    cyc(1);
    chk("t3_inflight", 32'(bus.inflight), 3);
    cyc(7);
    chk("t3_a_valid", 32'(bus.rsp_valid), 1);
    chk("t3_a_id", 32'(bus.rsp_id), 3);
    chk("t3_a_err", 32'(bus.rsp_err), 1);
    chk("t3_a_quot", 32'(bus.rsp_quot), 32'h1FF);
    chk("t3_a_rem", 32'(bus.rsp_rem), 0);
    cyc(1);
    chk("t3_b_valid", 32'(bus.rsp_valid), 1);
    chk("t3_b_id", 32'(bus.rsp_id), 0);
    chk("t3_b_err", 32'(bus.rsp_err), 1);
    chk("t3_b_quot", 32'(bus.rsp_quot), 32'h1FF);
    chk("t3_b_rem", 32'(bus.rsp_rem), 0);
    cyc(1);
    chk("t3_c_valid", 32'(bus.rsp_valid), 1);
    chk("t3_c_id", 32'(bus.rsp_id), 1);
    chk("t3_c_err", 32'(bus.rsp_err), 0);
    chk("t3_c_quot", 32'(bus.rsp_quot), 511);
    chk("t3_c_rem", 32'(bus.rsp_rem), 0);
    cyc(1);
    chk("t3_idle_valid", 32'(bus.rsp_valid), 0);
    chk("t3_idle_inflight", 32'(bus.inflight), 0);
    cyc(2);

    // Gapped requests at relative cycles 0, 2, 5 from requester 0
    for (int c = 0; c < 18; c++) begin
      bus.req_valid = '0;
      if (c == 0 || c == 2 || c == 5) set_req(0, 1000 + c, 9);
      #1;
      chk("t5_div_en", 32'(bus.div_en), (c == 1 || c == 3 || c == 6) ? 1 : 0);
      chk("t5_rsp_valid", 32'(bus.rsp_valid), (c == 11 || c == 13 || c == 16) ? 1 : 0);
      if (c == 11 || c == 13 || c == 16) begin
        chk("t5_rsp_quot", 32'(bus.rsp_quot), (1000 + c - 11) / 9);
        chk("t5_rsp_rem", 32'(bus.rsp_rem), (1000 + c - 11) % 9);
      end
      cyc(1);
    end
    bus.req_valid = '0;
    cyc(2);

    // Reset mid-flight: ops from 3, 1, 2 then reset four cycles after the first grant
    set_req(3, 1000, 7);
    cyc(1);
    bus.req_valid = '0;
    set_req(1, 2000, 9);
    cyc(1);
    bus.req_valid = '0;
    set_req(2, 3000, 11);
    cyc(1);
    bus.req_valid = '0;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("t4_div_en", 32'(bus.div_en), 0);
    for (int k = 0; k < 14; k++) begin
      chk("t4_no_rsp", 32'(bus.rsp_valid), 0);
      chk("t4_inflight", 32'(bus.inflight), 0);
      chk("t4_sync_err", 32'(bus.sync_err), 0);
      cyc(1);
    end

    // Round robin with all four requesters continuously valid
    for (int i = 0; i < NREQ; i++) begin
      bus.req_dividend[i*N +: N] = N'(2000 + i);
      bus.req_divisor[i*M +: M]  = M'(10 + i);
    end
    for (int k = 0; k < 24; k++) begin
      bus.req_valid = (k < 12) ? '1 : '0;
      #1;
      chk("t2_ready", 32'(bus.req_ready), (k < 12) ? (1 << (k % 4)) : 0);
      chk("t2_rsp_valid", 32'(bus.rsp_valid), (k >= 11 && k < 23) ? 1 : 0);
      if (k >= 11 && k < 23) begin
        chk("t2_rsp_id", 32'(bus.rsp_id), (k - 11) % 4);
        chk("t2_rsp_quot", 32'(bus.rsp_quot), (2000 + (k - 11) % 4) / (10 + (k - 11) % 4));
        chk("t2_rsp_rem", 32'(bus.rsp_rem), (2000 + (k - 11) % 4) % (10 + (k - 11) % 4));
      end
      if (k == 10 || k == 12) chk("t2_inflight_sat", 32'(bus.inflight), LAT);
      cyc(1);
    end
    bus.req_valid = '0;
    cyc(3);

    // Divider ready with no tag in flight
    chk("t6_sync_clean", 32'(bus.sync_err), 0);
    force_rdy = 1'b1;
    cyc(1);
    force_rdy = 1'b0;
    chk("t6_sync_set", 32'(bus.sync_err), 1);
    cyc(5);
    chk("t6_sync_sticky", 32'(bus.sync_err), 1);
    chk("t6_no_rsp", 32'(bus.rsp_valid), 0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("t6_sync_cleared", 32'(bus.sync_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Shares one pipelined restoring divider among NREQ requesters in the position-calculation path. The divider is the chain of one-bit divider cells (LAT stages).
- Round-robin arbitration: at most one division issued per cycle.
- Carries requester ID and error flags through a tag pipeline aligned to the divider latency. The divider has no tags and no stall.
- Returns each quotient/remainder to its originator as a one-cycle response pulse.

Parameters:
- NREQ, 4, number of requesters (≥2).
- IDW, 2, requester ID width; equals clog2(NREQ).
- N, 16, dividend width.
- M, 8, divisor width.
- LAT, 9, divider pipeline depth in cycles; must equal N-M+1 (quotient width Q).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_dividend  in  NREQ*N  packed dividends; slice i = [i*N +: N].
- req_divisor  in  NREQ*M  packed divisors; slice i = [i*M +: M].
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i].
- div_en  out  1  issue strobe to divider stage 0.
- div_dividend  out  N  dividend to divider.
- div_divisor  out  M  divisor to divider.
- div_rdy  in  1  final-stage ready from divider.
- div_quot  in  Q  final-stage quotient.
- div_rem  in  M  final-stage remainder.
- rsp_valid  out  1  one-cycle result pulse.
- rsp_id  out  IDW  requester index of result.
- rsp_quot  out  Q  quotient.
- rsp_rem  out  M  remainder.
- rsp_err  out  1  divide-by-zero or quotient overflow.
- inflight  out  clog2(LAT+1)  operations in the divider.
- sync_err  out  1  sticky: div_rdy disagreed with the tag pipeline.

Behaviour:
- Reset (sync, rst=1 at posedge): all registered outputs 0. Includes req_ready, div_en, div_dividend, div_divisor, rsp_*, inflight, sync_err. Tag pipeline valid bits cleared; RR pointer = NREQ-1, so requester 0 has highest priority next.
- Reset mid-operation: in-flight operations are dropped. No rsp_valid for any of them, even if div_rdy later pulses. sync_err stays 0 for those drops.
- Arbitration:
  - Combinational grant, registered issue.
  - Search starts at ptr+1 mod NREQ; the first i with req_valid[i] is granted.
  - req_ready = one-hot of the grant. All zero if no valid request.
  - On grant, ptr <= granted index. With no request, ptr holds.
  - One grant per cycle, every cycle. There is no backpressure from the divider.
- Requester rule: req_valid and data must hold until ready. The block samples data only in the grant cycle.
- Issue (cycle after grant):
  - div_en=1 for exactly one cycle, with div_dividend/div_divisor = the granted slices.
  - div_en=0 on cycles with no grant; the divider clears its stage then.
- Error flag, computed at grant time: err = (divisor==0) | ((dividend >> Q) >= divisor).
  - The operation is still issued.
  - Response data is forced: rsp_quot = all ones, rsp_rem = 0.
- Tag pipeline:
  - LAT-deep shift register of {valid, id, err}, entered together with div_en.
  - Tag exits in the same cycle the divider's final stage presents the result, i.e. LAT cycles after div_en.
- Response:
  - rsp_valid = exiting tag valid, registered.
  - rsp_valid rises 1 cycle after the result appears at div_quot/div_rem.
  - Total grant-to-rsp_valid latency = LAT+2 cycles.
  - rsp_id and rsp_err from the tag; rsp_quot/rsp_rem captured from div_quot/div_rem.
  - With rsp_valid=0, rsp_* data holds its last value.
- sync_err: set when exiting tag valid != div_rdy. Cleared only by rst.
- inflight: +1 on div_en, -1 on tag exit. Both in the same cycle leaves it unchanged. Max value LAT, never exceeded.
- Back-to-back: one issue per cycle sustains one response per cycle. Order is preserved; no reordering.

Decomposition:
- Package div_share_pkg:
  - derived width constant Q = N-M+1 and the LAT==Q check;
  - tag record layout {valid, id, err} with its width constant TAGW = 1+IDW+1.
- Sub-module rr_arbiter (NREQ): request vector plus pointer in, one-hot grant plus index out.
- Tag shift register stays inline.

Test Plan:
1. Single request: requester 2 sends 1000/7 → req_ready=4'b0100 same cycle; div_en next cycle; after LAT+2=11 cycles from grant, rsp_valid=1, rsp_id=2, quot=142, rem=6, err=0.
2. Round-robin: all four valid continuously from reset → grants in order 0,1,2,3,0,…; responses return IDs in the same order, one per cycle, inflight saturates at 9.
3. Errors:
   - 500/0 → rsp_err=1, quot=9'h1FF, rem=0.
   - 65535/1 (65535>>9=127 ≥1) → rsp_err=1.
   - 511/1 → err=0, quot=511, rem=0.
4. Reset mid-flight: issue 3 ops, assert rst 4 cycles after the first grant → no rsp_valid afterwards, inflight=0, ptr restarts at requester 0.
5. Gaps: requests in cycles 0,2,5 → div_en pulses only at 1,3,6; responses at 11,13,16; no spurious rsp_valid on bubble cycles.
6. Sync check: model forces div_rdy=1 with no tag → sync_err=1 sticky until rst.
